branch_resolve_r32i: RTL
========================

BRANCH_RESOLVE_R32I -- requirements
Module: branch_resolve_r32i

Interface
REQ-001 Parameter: dataW, 32, datapath width.
REQ-002 clock  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 in_valid  in  1  upstream offers instr plus operands.
REQ-005 in_ready  out  1  block accepts this cycle.
REQ-006 instr  in  32  fetched instruction word.
REQ-007 rs1_data, rs2_data  in  dataW each  register operands.
REQ-008 out_valid  out  1  resolved branch record valid.
REQ-009 out_ready  in  1  PC side consumes the record.
REQ-010 EQ, NE, LT, LTU, GE, GEU  out  1 each  comparison flags for the PC.
REQ-011 BranchControl  out  1  instruction is a branch/jump.
REQ-012 PCBranchType  out  3  branch code from shared package.
REQ-013 BranchOffset  out  dataW signed  sign-extended byte offset.
REQ-014 illegal  out  1  malformed branch encoding.
REQ-015 taken_count  out  16  saturating count of taken records delivered.

Function
REQ-016 Two-stage pipeline: S1 registers decode and immediate; S2 registers flags and record; latency 2 cycles from accept to out_valid with no stall.
REQ-017 Accept = in_valid & in_ready; deliver = out_valid & out_ready.
REQ-018 S2 loads when empty or delivering; S1 advances when S2 loads; in_ready = !S1_valid | S1 advancing.
REQ-019 out_valid and the whole record stay stable while out_valid & !out_ready.
REQ-020 Opcode 1100011 (B-type): BranchControl=1, PCBranchType=funct3, BranchOffset = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
REQ-021 B-type funct3 010 or 011: illegal=1, BranchControl=0, BranchOffset=0.
REQ-022 Opcode 1101111 (JAL): BranchControl=1, PCBranchType=JAL, BranchOffset = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
REQ-023 Any other opcode: BranchControl=0, PCBranchType=BEQ, BranchOffset=0, illegal=0.
REQ-024 Flags always computed from operands: EQ=(a==b), NE=!EQ, LT signed a<b, LTU unsigned a<b, GE=!LT, GEU=!LTU.
REQ-025 Taken = BranchControl & (JAL or flag selected by PCBranchType).
REQ-026 Flush: on delivery of a taken record, S1 is invalidated and any accept in the same cycle is discarded (wrong path).
REQ-027 taken_count increments on each taken delivery, saturates at 16'hFFFF, never wraps.
REQ-028 Back-to-back accepts sustain one record per cycle when out_ready stays high.

Reset
REQ-029 reset high at a clock edge clears S1/S2 valid, out_valid=0, all flags 0, BranchControl=0, PCBranchType=BEQ, BranchOffset=0, illegal=0, taken_count=0.
REQ-030 in_ready=0 during reset; reset mid-stall drops held records without delivery.

Structure
REQ-031 Package branch_pkg holds the 3-bit branch codes (BEQ=000, BNEQ=001, JAL=010, BLT=100, BGE=101, BLTU=110, BGEU=111), the opcode constants, and a packed record typedef for the S2 contents.
REQ-032 One sub-module, branch_cmp_r32i (combinational flag generation), instantiated in S2.

Verification
REQ-033 BEQ, rs1=rs2=5, imm=+40 -> two cycles later out_valid=1, EQ=1, GE=1, GEU=1, BranchOffset=40, taken_count=1.
REQ-034 BLT rs1=-1, rs2=1 -> LT=1, LTU=0, taken; BLTU same operands -> LTU=0, not taken, taken_count unchanged.
REQ-035 JAL imm=-8 -> BranchControl=1, PCBranchType=JAL, BranchOffset=32'hFFFFFFF8; the instruction accepted right behind it is flushed and never appears at the output.
REQ-036 out_ready held low 3 cycles with 3 offered -> in_ready=0 after two are held; record stable; all three delivered in order once released.
REQ-037 B-type funct3=011 -> illegal=1, BranchControl=0; ADD opcode -> BranchControl=0, BranchOffset=0.
REQ-038 reset asserted while S2 is stalled -> next cycle out_valid=0, taken_count=0, PCBranchType=BEQ.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch codes, opcode constants and the S2 record layout
// for the RV32I branch resolution pipeline.
package branch_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNEQ = 3'b001,
        JAL  = 3'b010,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_type_e;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic     eq;
        logic     ne;
        logic     lt;
        logic     ltu;
        logic     ge;
        logic     geu;
        logic     branch_control;
        br_type_e br_type;
        logic     illegal;
        logic     taken;
    } s2_rec_t;

    function automatic logic br_taken(
        input br_type_e t,
        input logic     eq,
        input logic     ne,
        input logic     lt,
        input logic     ltu,
        input logic     ge,
        input logic     geu
    );
        logic r;
        case (t)
            BEQ:     r = eq;
            BNEQ:    r = ne;
            JAL:     r = 1'b1;
            BLT:     r = lt;
            BGE:     r = ge;
            BLTU:    r = ltu;
            BGEU:    r = geu;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_cmp_r32i.sv
// Combinational operand comparison producing the six branch condition flags.
module branch_cmp_r32i #(
    parameter int dataW = 32
) (
    input  logic [dataW-1:0] a,
    input  logic [dataW-1:0] b,
    output logic             eq,
    output logic             ne,
    output logic             lt,
    output logic             ltu,
    output logic             ge,
    output logic             geu
);

    always_comb begin
        eq  = (a == b);
        ne  = ~eq;
        lt  = ($signed(a) < $signed(b));
        ltu = (a < b);
        ge  = ~lt;
        geu = ~ltu;
    end

endmodule

// File: rtl/branch_resolve_r32i.sv
// Two-stage branch resolution: S1 holds decode/immediate and operands,
// S2 holds the compared flags and the record presented to the PC logic.
module branch_resolve_r32i
    import branch_pkg::*;
#(
    parameter int dataW = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             instr,
    input  logic [dataW-1:0]        rs1_data,
    input  logic [dataW-1:0]        rs2_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    EQ,
    output logic                    NE,
    output logic                    LT,
    output logic                    LTU,
    output logic                    GE,
    output logic                    GEU,
    output logic                    BranchControl,
    output logic [2:0]              PCBranchType,
    output logic signed [dataW-1:0] BranchOffset,
    output logic                    illegal,
    output logic [15:0]             taken_count
);

    logic             s1_valid_q, s1_valid_d;
    logic             s1_ctrl_q, s1_ctrl_d;
    br_type_e         s1_type_q, s1_type_d;
    logic [dataW-1:0] s1_off_q, s1_off_d;
    logic             s1_ill_q, s1_ill_d;
    logic [dataW-1:0] s1_rs1_q, s1_rs1_d;
    logic [dataW-1:0] s1_rs2_q, s1_rs2_d;

    logic             s2_valid_q, s2_valid_d;
    s2_rec_t          s2_rec_q, s2_rec_d;
    logic [dataW-1:0] s2_off_q, s2_off_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             deliver, flush, s2_load, accept;
    logic             dec_ctrl, dec_ill;
    br_type_e         dec_type;
    logic [dataW-1:0] dec_off;
    logic [12:0]      imm_b;
    logic [20:0]      imm_j;
    logic             c_eq, c_ne, c_lt, c_ltu, c_ge, c_geu;

    assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec_ctrl = 1'b0;
        dec_type = BEQ;
        dec_off  = '0;
        dec_ill  = 1'b0;
        case (instr[6:0])
            OPC_BRANCH: begin
                // funct3 010/011 are unused B-type encodings
                if (instr[14:13] == 2'b01) begin
                    dec_ill = 1'b1;
                end else begin
                    dec_ctrl = 1'b1;
                    dec_type = br_type_e'(instr[14:12]);
                    dec_off  = {{(dataW-13){imm_b[12]}}, imm_b};
                end
            end
            OPC_JAL: begin
                dec_ctrl = 1'b1;
                dec_type = JAL;
                dec_off  = {{(dataW-21){imm_j[20]}}, imm_j};
            end
            default: ;
        endcase
    end

    branch_cmp_r32i #(.dataW(dataW)) u_cmp (
        .a   (s1_rs1_q),
        .b   (s1_rs2_q),
        .eq  (c_eq),
        .ne  (c_ne),
        .lt  (c_lt),
        .ltu (c_ltu),
        .ge  (c_ge),
        .geu (c_geu)
    );

    always_comb begin
        deliver  = s2_valid_q & out_ready;
        flush    = deliver & s2_rec_q.taken;
        s2_load  = ~s2_valid_q | deliver;
        in_ready = ~reset & (~s1_valid_q | s2_load);
        accept   = in_valid & in_ready;

        s1_valid_d = s1_valid_q;
        s1_ctrl_d  = s1_ctrl_q;
        s1_type_d  = s1_type_q;
        s1_off_d   = s1_off_q;
        s1_ill_d   = s1_ill_q;
        s1_rs1_d   = s1_rs1_q;
        s1_rs2_d   = s1_rs2_q;
        if (s2_load) s1_valid_d = 1'b0;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_ctrl_d  = dec_ctrl;
            s1_type_d  = dec_type;
            s1_off_d   = dec_off;
            s1_ill_d   = dec_ill;
            s1_rs1_d   = rs1_data;
            s1_rs2_d   = rs2_data;
        end
        // A taken delivery kills both S1 and whatever is accepted alongside it
        if (flush) s1_valid_d = 1'b0;

        s2_valid_d = s2_valid_q;
        s2_rec_d   = s2_rec_q;
        s2_off_d   = s2_off_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q & ~flush;
            s2_rec_d   = '0;
            s2_off_d   = '0;
            if (s1_valid_q & ~flush) begin
                s2_rec_d.eq             = c_eq;
                s2_rec_d.ne             = c_ne;
                s2_rec_d.lt             = c_lt;
                s2_rec_d.ltu            = c_ltu;
                s2_rec_d.ge             = c_ge;
                s2_rec_d.geu            = c_geu;
                s2_rec_d.branch_control = s1_ctrl_q;
                s2_rec_d.br_type        = s1_type_q;
                s2_rec_d.illegal        = s1_ill_q;
                s2_rec_d.taken          = s1_ctrl_q &
                    br_taken(s1_type_q, c_eq, c_ne, c_lt, c_ltu, c_ge, c_geu);
                s2_off_d                = s1_off_q;
            end
        end

        cnt_d = cnt_q;
        if (flush && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_ctrl_q  <= 1'b0;
            s1_type_q  <= BEQ;
            s1_off_q   <= '0;
            s1_ill_q   <= 1'b0;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_rec_q   <= '0;
            s2_off_q   <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ctrl_q  <= s1_ctrl_d;
            s1_type_q  <= s1_type_d;
            s1_off_q   <= s1_off_d;
            s1_ill_q   <= s1_ill_d;
            s1_rs1_q   <= s1_rs1_d;
            s1_rs2_q   <= s1_rs2_d;
            s2_valid_q <= s2_valid_d;
            s2_rec_q   <= s2_rec_d;
            s2_off_q   <= s2_off_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid     = s2_valid_q;
    assign EQ            = s2_rec_q.eq;
    assign NE            = s2_rec_q.ne;
    assign LT            = s2_rec_q.lt;
    assign LTU           = s2_rec_q.ltu;
    assign GE            = s2_rec_q.ge;
    assign GEU           = s2_rec_q.geu;
    assign BranchControl = s2_rec_q.branch_control;
    assign PCBranchType  = s2_rec_q.br_type;
    assign BranchOffset  = s2_off_q;
    assign illegal       = s2_rec_q.illegal;
    assign taken_count   = cnt_q;

endmodule
